// File: rtl/data_path.sv
// Single-bus datapath: sixteen GPRs, PC/IR/Y/HI/LO, 64-bit Z, MAR/MDR,
// a 512x32 RAM and a two-operand ALU (A = Y, B = bus).

// One bus-loaded register lane.
module dp_reg #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // Load on select; clear wins.
   always_ff @(posedge clock) begin
      if (clear)   q <= '0;
      else if (ld) q <= d;
   end
endmodule

module data_path #(
   parameter int NUM_REGS = 16,
   parameter int VEC_W    = 32
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic        PCin, IRin, Yin, HIin, LOin,
   input  logic        PCout, Yout, HIout, LOout, MDRout, Zhighout, Zlowout,
   input  logic        InPortout,
   input  logic        CSignOut,
   input  logic        ZHighIn, ZLowIn, Cin,
   input  logic        IncPC,
   input  logic        MARin,
   input  logic        MDRin,
   input  logic        Read, Write,
   input  logic [4:0]  opcode,
   input  logic [8:0]  Address,
   input  logic [31:0] Mdatain,
   input  logic [31:0] InPort_data,
   output logic [31:0] BusMuxOut,
   output logic [31:0] BusMuxInMDR
);
   logic [NUM_REGS-1:0]            rin, rout;
   logic [NUM_REGS-1:0][VEC_W-1:0] r;
   logic [31:0] pc, ir, y, hi, lo, mdr, mdr_mux, bus, csign;
   logic [63:0] z, c;
   logic [8:0]  mar;
   logic [31:0] ram [512];

   assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_gpr
         dp_reg #(.W(VEC_W)) u_gpr (.clock(clock), .clear(clear), .ld(rin[g]), .d(bus), .q(r[g]));
      end
   endgenerate

   dp_reg #(.W(32)) u_ir (.clock(clock), .clear(clear), .ld(IRin), .d(bus), .q(ir));
   dp_reg #(.W(32)) u_y  (.clock(clock), .clear(clear), .ld(Yin),  .d(bus), .q(y));
   dp_reg #(.W(32)) u_hi (.clock(clock), .clear(clear), .ld(HIin), .d(bus), .q(hi));
   dp_reg #(.W(32)) u_lo (.clock(clock), .clear(clear), .ld(LOin), .d(bus), .q(lo));

   // Constant field of IR, sign-extended from bit 18.
   assign csign   = {{13{ir[18]}}, ir[18:0]};
   assign mdr_mux = Read ? ram[mar] : Mdatain;

   // Wired-OR bus: every selected source contributes; idle bus reads zero.
   always_comb begin
      bus = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rout[i]) bus = bus | r[i];
      if (PCout)     bus = bus | pc;
      if (Yout)      bus = bus | y;
      if (HIout)     bus = bus | hi;
      if (LOout)     bus = bus | lo;
      if (MDRout)    bus = bus | mdr;
      if (Zhighout)  bus = bus | z[63:32];
      if (Zlowout)   bus = bus | z[31:0];
      if (InPortout) bus = bus | InPort_data;
      if (CSignOut)  bus = bus | csign;
   end

   // ALU: A = Y, B = bus; only MUL/DIV populate the upper word.
   always_comb begin
      logic [4:0]         sh;
      logic signed [63:0] prod;
      logic signed [31:0] quo, rem;
      sh   = bus[4:0];
      prod = $signed(y) * $signed(bus);
      quo  = '1;
      rem  = $signed(y);
      if (bus != '0) begin
         quo = $signed(y) / $signed(bus);
         rem = $signed(y) % $signed(bus);
      end
      c = '0;
      case (opcode)
         5'b00011: c[31:0] = y + bus;
         5'b00100: c[31:0] = y - bus;
         5'b00101: c[31:0] = y & bus;
         5'b00110: c[31:0] = y | bus;
         5'b00111: c[31:0] = y >> sh;
         5'b01000: c[31:0] = $signed(y) >>> sh;
         5'b01001: c[31:0] = y << sh;
         5'b01010: c[31:0] = (y >> sh) | (y << (6'd32 - {1'b0, sh}));
         5'b01011: c[31:0] = (y << sh) | (y >> (6'd32 - {1'b0, sh}));
         5'b01111: c = prod;
         5'b10000: c = {rem, quo};
         5'b10001: c[31:0] = -bus;
         5'b10010: c[31:0] = ~bus;
         default:  c = '0;
      endcase
   end

   // Z halves load independently; Cin loads the full product/quotient pair.
   always_ff @(posedge clock) begin
      if (clear) z <= '0;
      else begin
         if (Cin || ZHighIn) z[63:32] <= c[63:32];
         if (Cin || ZLowIn)  z[31:0]  <= c[31:0];
      end
   end

   // PC: a bus load beats an increment.
   always_ff @(posedge clock) begin
      if (clear)      pc <= '0;
      else if (PCin)  pc <= bus;
      else if (IncPC) pc <= pc + 32'd1;
   end

   // Memory address and data registers.
   always_ff @(posedge clock) begin
      if (clear) begin
         mar <= '0;
         mdr <= '0;
      end else begin
         if (MARin) mar <= Address;
         if (MDRin) mdr <= mdr_mux;
      end
   end

   // RAM survives clear; the write data is the MDR mux, not the old MDR.
   always_ff @(posedge clock) begin
      if (Write) ram[mar] <= mdr_mux;
   end

   assign BusMuxOut   = bus;
   assign BusMuxInMDR = mdr;
endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
   logic clock = 1'b0, clear = 1'b0;
   logic [15:0] rin = '0, rout = '0;
   logic PCin = 0, IRin = 0, Yin = 0, HIin = 0, LOin = 0;
   logic PCout = 0, Yout = 0, HIout = 0, LOout = 0, MDRout = 0, Zhighout = 0, Zlowout = 0;
   logic InPortout = 0, CSignOut = 0, ZHighIn = 0, ZLowIn = 0, Cin = 0, IncPC = 0;
   logic MARin = 0, MDRin = 0, Read = 0, Write = 0;
   logic [4:0]  opcode = '0;
   logic [8:0]  Address = '0;
   logic [31:0] Mdatain = '0, InPort_data = '0;
   logic [31:0] BusMuxOut, BusMuxInMDR;

   int total = 0, bad = 0;
   logic [31:0] sbq[$];

   always #5 clock = ~clock;

   data_path dut (
      .clock(clock), .clear(clear),
      .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
      .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
      .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
      .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
      .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
      .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
      .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
      .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
      .PCin(PCin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
      .PCout(PCout), .Yout(Yout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
      .Zhighout(Zhighout), .Zlowout(Zlowout), .InPortout(InPortout), .CSignOut(CSignOut),
      .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin), .IncPC(IncPC),
      .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
      .opcode(opcode), .Address(Address), .Mdatain(Mdatain), .InPort_data(InPort_data),
      .BusMuxOut(BusMuxOut), .BusMuxInMDR(BusMuxInMDR)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   // Drop every control back to idle.
   task automatic idle();
      rin = '0; rout = '0;
      {PCin, IRin, Yin, HIin, LOin} = '0;
      {PCout, Yout, HIout, LOout, MDRout, Zhighout, Zlowout} = '0;
      {InPortout, CSignOut, ZHighIn, ZLowIn, Cin, IncPC} = '0;
      {MARin, MDRin, Read, Write} = '0;
      clear = 1'b0; opcode = '0;
   endtask

   // Apply the current controls for one edge, then idle.
   task automatic cyc();
      @(posedge clock); #1;
      idle();
   endtask

   // Out-selects already driven by caller; expected value goes through the queue.
   task automatic expect_bus(input string tag, input logic [31:0] e);
      sbq.push_back(e);
      #1;
      chk(tag, BusMuxOut, sbq.pop_front());
      idle();
   endtask

   task automatic expect_mdr(input string tag, input logic [31:0] e);
      sbq.push_back(e);
      #1;
      chk(tag, BusMuxInMDR, sbq.pop_front());
   endtask

   task automatic load_reg(input int n, input logic [31:0] v);
      Mdatain = v; MDRin = 1; cyc();
      MDRout = 1; rin[n] = 1; cyc();
   endtask

   typedef struct {
      logic [31:0] a, b;
      logic [4:0]  op;
      logic [31:0] lo, hi;
      string       tag;
   } alu_vec_t;

   alu_vec_t vecs[$];

   initial begin
      vecs.push_back('{32'd5,        32'd7,  5'b00011, 32'd12,         32'd0,         "add"});
      vecs.push_back('{32'hFFFFFFFF, 32'd1,  5'b00011, 32'd0,          32'd0,         "add_wrap"});
      vecs.push_back('{32'd3,        32'd5,  5'b00100, 32'hFFFFFFFE,   32'd0,         "sub"});
      vecs.push_back('{32'hF0F0_00FF,32'h0FF0_0F0F, 5'b00101, 32'h00F0_000F, 32'd0, "and"});
      vecs.push_back('{32'hF000_0001,32'h0000_0F00, 5'b00110, 32'hF000_0F01, 32'd0, "or"});
      vecs.push_back('{32'h8000_0000,32'd4,  5'b00111, 32'h0800_0000,  32'd0,         "shr"});
      vecs.push_back('{32'h8000_0000,32'd4,  5'b01000, 32'hF800_0000,  32'd0,         "shra"});
      vecs.push_back('{32'd1,        32'd31, 5'b01001, 32'h8000_0000,  32'd0,         "shl"});
      vecs.push_back('{32'd1,        32'd33, 5'b01001, 32'd2,          32'd0,         "shl_amt5"});
      vecs.push_back('{32'd1,        32'd1,  5'b01010, 32'h8000_0000,  32'd0,         "ror"});
      vecs.push_back('{32'h8000_0001,32'd4,  5'b01011, 32'h0000_0018,  32'd0,         "rol"});
      vecs.push_back('{32'hFFFFFFFA, 32'd4,  5'b01111, 32'hFFFFFFE8,   32'hFFFFFFFF,  "mul"});
      vecs.push_back('{32'd17,       32'd5,  5'b10000, 32'd3,          32'd2,         "div"});
      vecs.push_back('{32'd17,       32'd0,  5'b10000, 32'hFFFFFFFF,   32'd17,        "div0"});
      vecs.push_back('{32'd9,        32'd5,  5'b10001, 32'hFFFFFFFB,   32'd0,         "neg"});
      vecs.push_back('{32'd9,        32'h0F0F0F0F, 5'b10010, 32'hF0F0F0F0, 32'd0,   "not"});
      vecs.push_back('{32'd9,        32'd5,  5'b00000, 32'd0,          32'd0,         "bad_op"});

      idle();
      clear = 1; cyc();
      expect_bus("rst_bus", 32'd0);
      expect_mdr("rst_mdr", 32'd0);

      // Store then load through RAM[5].
      MARin = 1; Address = 9'd5; cyc();
      Mdatain = 32'h12345678; MDRin = 1; Write = 1; cyc();
      expect_mdr("st_mdr", 32'h12345678);
      Mdatain = 32'h0; MDRin = 1; cyc();
      MARin = 1; Address = 9'd5; cyc();
      Read = 1; MDRin = 1; cyc();
      expect_mdr("ld_mdr", 32'h12345678);
      MDRout = 1; rin[4] = 1; cyc();
      rout[4] = 1; expect_bus("ld_r4", 32'h12345678);

      // ALU table: R2 -> Y, R3 on bus as B.
      foreach (vecs[i]) begin
         load_reg(2, vecs[i].a);
         load_reg(3, vecs[i].b);
         rout[2] = 1; Yin = 1; cyc();
         rout[3] = 1; opcode = vecs[i].op; Cin = 1; cyc();
         Zlowout = 1; rin[1] = 1; cyc();
         rout[1] = 1; expect_bus({vecs[i].tag, "_lo"}, vecs[i].lo);
         Zhighout = 1; expect_bus({vecs[i].tag, "_hi"}, vecs[i].hi);
      end

      // Split Z load: only the low half changes (Z high still 0 from bad_op).
      load_reg(2, 32'd1); load_reg(3, 32'd2);
      rout[2] = 1; Yin = 1; cyc();
      rout[3] = 1; opcode = 5'b01111; ZLowIn = 1; cyc();
      Zlowout = 1; expect_bus("zlow_only", 32'd2);
      Zhighout = 1; expect_bus("zhigh_kept", 32'd0);

      // PC wrap and priority.
      Mdatain = 32'hFFFFFFFF; MDRin = 1; cyc();
      MDRout = 1; PCin = 1; cyc();
      IncPC = 1; cyc();
      PCout = 1; expect_bus("pc_wrap", 32'd0);
      Mdatain = 32'd8; MDRin = 1; cyc();
      MDRout = 1; PCin = 1; IncPC = 1; cyc();
      PCout = 1; expect_bus("pc_prio", 32'd8);
      IncPC = 1; cyc();
      PCout = 1; expect_bus("pc_inc", 32'd9);

      // Sign-extended IR constant.
      Mdatain = 32'h0007FFFF; MDRin = 1; cyc();
      MDRout = 1; IRin = 1; cyc();
      CSignOut = 1; expect_bus("csign_neg", 32'hFFFFFFFF);
      Mdatain = 32'h0003FFFF; MDRin = 1; cyc();
      MDRout = 1; IRin = 1; cyc();
      CSignOut = 1; expect_bus("csign_pos", 32'h0003FFFF);

      // HI/LO, input port and wired-OR of two sources.
      Mdatain = 32'hCAFE0000; MDRin = 1; cyc();
      MDRout = 1; HIin = 1; cyc();
      HIout = 1; expect_bus("hi", 32'hCAFE0000);
      Mdatain = 32'h0000BEEF; MDRin = 1; cyc();
      MDRout = 1; LOin = 1; cyc();
      LOout = 1; expect_bus("lo", 32'h0000BEEF);
      HIout = 1; LOout = 1; expect_bus("bus_or", 32'hCAFEBEEF);
      InPort_data = 32'hA5A5_5A5A; InPortout = 1; expect_bus("inport", 32'hA5A5_5A5A);

      // Clear mid-operation overrides loads; RAM keeps its data.
      Mdatain = 32'h1111; MDRin = 1; cyc();
      clear = 1; MDRout = 1; rin[4] = 1; Mdatain = 32'h9; MDRin = 1; cyc();
      rout[4] = 1; expect_bus("clr_r4", 32'd0);
      expect_mdr("clr_mdr", 32'd0);
      PCout = 1; expect_bus("clr_pc", 32'd0);
      MARin = 1; Address = 9'd5; cyc();
      Read = 1; MDRin = 1; cyc();
      expect_mdr("ram_kept", 32'h12345678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end
endmodule
